// File: rtl/apb_pkg.sv
// apb_pkg: shared types for the APB initiator.
// FSM state enum and the latched response bundle.
package apb_pkg;

  localparam int APB_DW = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_mst_state_t;

  typedef struct packed {
    logic [APB_DW-1:0] rdata;
    logic              err;
    logic              timeout;
  } apb_mst_rsp_t;

endpackage

// File: rtl/apb_mst_if.sv
// apb_mst_if: command, response and APB bus bundle.
// master = initiator side, slave = requester/responder side.
interface apb_mst_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  modport master (
    input  cmd_valid, cmd_write,
    input  cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_rdata,
    output rsp_err, rsp_timeout,
    input  rsp_ready,
    output psel, penable, pwrite,
    output paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write,
    output cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata,
    input  rsp_err, rsp_timeout,
    output rsp_ready,
    input  psel, penable, pwrite,
    input  paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_mst.sv
// apb_mst: single-beat command -> APB SETUP/ACCESS initiator.
// Ports: pclk, presetn (async low), bus (cmd/rsp/APB). Macro APB_MST_TIMEOUT_EN.
module apb_mst
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = APB_DW,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic       pclk,
  input logic       presetn,
  apb_mst_if.master bus
);

  apb_mst_state_t state_q, state_d;
  apb_mst_rsp_t   rsp_q, rsp_d;

  logic                  psel_q, psel_d;
  logic                  pen_q, pen_d;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  done;
  logic                  tmo;

  assign done = (state_q == ACCESS) && bus.pready;

`ifdef APB_MST_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wcnt_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wcnt_q <= '0;
    end else if (state_q == SETUP) begin
      wcnt_q <= '0;
    end else if (state_q == ACCESS && !bus.pready) begin
      wcnt_q <= wcnt_q + CW'(1);
    end
  end

  // ready on the limit cycle still wins
  assign tmo = (state_q == ACCESS) && !bus.pready &&
               (wcnt_q == CW'(TIMEOUT_CYCLES));
`else
  assign tmo = 1'b0;

  // counter not built; parameter kept for a uniform list
  if (TIMEOUT_CYCLES < 0) begin : g_no_tmo
  end
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.cmd_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done || tmo) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // strobes decoded from next state, then registered
  always_comb begin
    psel_d = (state_d == SETUP) || (state_d == ACCESS);
    pen_d  = (state_d == ACCESS);
  end

  always_comb begin
    rsp_d = rsp_q;
    unique case (1'b1)
      done: begin
        rsp_d.rdata   = pwrite_q ? '0 : APB_DW'(bus.prdata);
        rsp_d.err     = bus.pslverr;
        rsp_d.timeout = 1'b0;
      end
      tmo: begin
        rsp_d.rdata   = '0;
        rsp_d.err     = 1'b1;
        rsp_d.timeout = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      psel_q   <= 1'b0;
      pen_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rsp_q    <= '0;
    end else begin
      psel_q <= psel_d;
      pen_q  <= pen_d;
      rsp_q  <= rsp_d;
      if (state_q == IDLE && bus.cmd_valid) begin
        pwrite_q <= bus.cmd_write;
        paddr_q  <= bus.cmd_addr;
        pwdata_q <= bus.cmd_wdata;
      end
    end
  end

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.rsp_valid   = (state_q == RESP);
  assign bus.rsp_rdata   = DATA_WIDTH'(rsp_q.rdata);
  assign bus.rsp_err     = rsp_q.err;
  assign bus.rsp_timeout = rsp_q.timeout;
  assign bus.psel        = psel_q;
  assign bus.penable     = pen_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;

endmodule

// File: doc/apb_mst.md
# apb_mst

APB initiator that turns single-beat commands from an on-chip requester (debug bridge, boot loader, test sequencer) into APB transfers toward peripheral responders such as the PMU reset-control register. Each accepted command runs one full SETUP/ACCESS sequence. The block waits for `pready` and returns read data and the error status through a response handshake. There is one transfer in flight at a time.

## Interface
- ADDR_WIDTH, 32, width of `cmd_addr`/`paddr`
- DATA_WIDTH, 32, width of all data buses
- TIMEOUT_CYCLES, 255, number of ACCESS cycles without `pready` before abort (used only with the timeout feature)
- pclk  input  1  clock
- presetn  input  1  reset; asynchronous, active-low; clock pclk
- cmd_valid  input  1  command request
- cmd_ready  output  1  command accepted when high together with cmd_valid
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_WIDTH  transfer address
- cmd_wdata  input  DATA_WIDTH  write data
- rsp_valid  output  1  response available
- rsp_ready  input  1  response consumed when high together with rsp_valid
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and for aborted transfers
- rsp_err  output  1  slave error or timeout
- rsp_timeout  output  1  transfer aborted by timeout (tied 0 without the timeout feature)
- psel, penable, pwrite  output  1  APB control
- paddr  output  ADDR_WIDTH  APB address
- pwdata  output  DATA_WIDTH  APB write data
- prdata  input  DATA_WIDTH  APB read data
- pready  input  1  APB ready; tie to 1 for responders with no wait states
- pslverr  input  1  APB error; tie to 0 if unsupported

## Operation
- The FSM has four states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- `cmd_ready` = (state == IDLE). It is a combinational output and is therefore 1 during reset.
- IDLE → SETUP when `cmd_valid` is high.
  - `paddr`, `pwrite` and `pwdata` are registered from the command on that edge.
- SETUP: `psel` = 1, `penable` = 0. Always advances to ACCESS after one cycle.
- ACCESS: `psel` = 1, `penable` = 1.
  - While `pready` = 0, stay in ACCESS.
  - On `pready` = 1:
    - Latch `rsp_rdata`: `prdata` for a read, 0 for a write.
    - Latch `rsp_err` = `pslverr`.
    - Go to RESP. `psel` and `penable` drop on the same edge.
- RESP: `rsp_valid` = 1. Response fields are held stable until `rsp_ready` is high; then go to IDLE.
- `paddr`, `pwrite` and `pwdata` hold their values from SETUP through the end of ACCESS. After the transfer they keep their last value; they do not return to 0.
- `psel` and `penable` are registered directly from the next state, so they are glitch-free.
- A command arriving while the block is not in IDLE is not accepted. The requester must hold `cmd_valid` and its payload stable until accepted.
- Reset values: `psel`, `penable`, `pwrite` = 0; `paddr`, `pwdata` = 0; `rsp_valid` = 0; `rsp_rdata` = 0; `rsp_err` = 0; `rsp_timeout` = 0.
- Reset asserted mid-transfer returns the block to IDLE immediately (asynchronously) and all outputs take their reset values. No response is produced for the aborted command.

## Timing
- Command handshake on edge 0 → SETUP during cycle 1 → ACCESS during cycle 2.
- With `pready` = 1 in cycle 2, `rsp_valid` = 1 in cycle 3. The minimum command-to-response latency is 3 cycles.
- Each wait state adds one cycle.
- With `rsp_ready` held high, the response lasts exactly one cycle.
- The next command can be accepted in the cycle after the response handshake. Peak throughput is therefore one transfer per 4 cycles.
- `prdata` and `pslverr` are sampled only on an edge where `psel & penable & pready` is true. They are ignored at all other times.

## Configuration
- APB_MST_TIMEOUT_EN defined:
  - An ACCESS wait counter of width $clog2(TIMEOUT_CYCLES+1) is cleared on entry to ACCESS and increments on every ACCESS cycle with `pready` = 0.
  - When the counter equals TIMEOUT_CYCLES and `pready` is still 0, the transfer is aborted: go to RESP with `rsp_err` = 1, `rsp_timeout` = 1, `rsp_rdata` = 0, and `psel`/`penable` dropped.
  - If `pready` = 1 arrives on the same cycle the counter reaches TIMEOUT_CYCLES, the transfer completes normally and no timeout is flagged.
- APB_MST_TIMEOUT_EN undefined: no counter is built, ACCESS waits indefinitely, and `rsp_timeout` is constant 0.

## Structure
- The shared package `apb_pkg` holds:
  - `apb_mst_state_t`, the enum IDLE/SETUP/ACCESS/RESP;
  - `apb_mst_rsp_t`, a packed struct of rdata, err and timeout.
- Single module; no sub-module. The timeout counter is inline under the macro.

## Test plan
- Write 0x00000001 to 0x00000000 with `pready` tied 1:
  - `psel` is high for 2 cycles and `penable` for 1;
  - `rsp_valid` appears 3 cycles after acceptance with `rsp_err` = 0 and `rsp_rdata` = 0.
- Read from 0x00000000 with the responder returning 0x00000001 and 2 wait states:
  - ACCESS lasts 3 cycles;
  - `rsp_rdata` = 0x00000001 and `paddr` is stable throughout.
- Read with `pslverr` = 1 on the ready cycle → `rsp_err` = 1, `rsp_timeout` = 0.
- Hold `rsp_ready` = 0 for 5 cycles with a new `cmd_valid` pending:
  - response fields stay stable and `cmd_ready` = 0;
  - the command is accepted in the cycle after `rsp_ready` rises.
- APB_MST_TIMEOUT_EN with TIMEOUT_CYCLES = 4 and `pready` stuck 0:
  - abort after 4 wait cycles with `rsp_err` = 1, `rsp_timeout` = 1;
  - a second run with `pready` = 1 on the 4th wait cycle completes normally.
- Deassert `presetn` during ACCESS:
  - `psel`, `penable` and `rsp_valid` are 0 immediately;
  - after release, `cmd_ready` = 1 and the next command completes normally.
